// File: rtl/alu_share_arb_pkg.sv
// alu_share_arb_pkg: ALU op encodings, flag bit order and response-slot states
// shared by the ALU arbiter and its round-robin picker.
package alu_share_arb_pkg;
    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_SLTU = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_NOR  = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_SLT  = 3'b111
    } alu_op_e;

    localparam int FLAG_OVF  = 2;
    localparam int FLAG_COUT = 1;
    localparam int FLAG_ZERO = 0;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_e;

    function automatic logic [2:0] pack_flags(input logic ovf, input logic cout, input logic zero);
        logic [2:0] f;
        f[FLAG_OVF]  = ovf;
        f[FLAG_COUT] = cout;
        f[FLAG_ZERO] = zero;
        return f;
    endfunction
endpackage

// File: rtl/alu_share_arb_rr_pick.sv
// alu_share_arb_rr_pick: combinational round-robin picker; the search starts
// at last+1 mod NREQ and returns a one-hot grant, its index and an any flag.
module alu_share_arb_rr_pick #(
    parameter int NREQ = 2,
    localparam int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);
    // Walk from the farthest position back to the nearest so the nearest valid wins.
    always_comb begin
        idx = '0;
        for (int k = NREQ; k >= 1; k--)
            for (int j = 0; j < NREQ; j++)
                if (valid[j] && ((int'(last) + k) % NREQ) == j) idx = IW'(j);
    end

    assign any   = |valid;
    assign grant = any ? NREQ'(1) << idx : '0;
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one external ALU among NREQ requesters
// with a single registered response slot. ALU_SHARE_ARB_STATS_EN adds grant/stall counters.
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NREQ = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*DATA_WIDTH-1:0] req_a,
    input  logic [NREQ*DATA_WIDTH-1:0] req_b,
    input  logic [NREQ*3-1:0]          req_op,
    output logic [NREQ-1:0]            rsp_valid,
    input  logic [NREQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_result,
    output logic [2:0]                 rsp_flags,
    output logic [DATA_WIDTH-1:0]      alu_a,
    output logic [DATA_WIDTH-1:0]      alu_b,
    output logic [2:0]                 alu_op,
    input  logic [DATA_WIDTH-1:0]      alu_result,
    input  logic                       alu_ovf,
    input  logic                       alu_cout,
`ifdef ALU_SHARE_ARB_STATS_EN
    output logic [NREQ*16-1:0]         stat_grants,
    output logic [15:0]                stat_stalls,
`endif
    input  logic                       alu_zero
);
    localparam int IW = $clog2(NREQ);

    slot_state_e     state, state_next;
    logic [IW-1:0]   own, last, gidx;
    logic [NREQ-1:0] grant;
    logic            any, rsp_fire, can_issue, accept;

    alu_share_arb_rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .valid (req_valid),
        .last  (last),
        .grant (grant),
        .idx   (gidx),
        .any   (any)
    );

    assign rsp_fire  = (state == FULL) && rsp_ready[own];
    assign can_issue = (state == EMPTY) || rsp_fire;
    // Held in reset the slot reads EMPTY, so gate on resetn to accept nothing.
    assign accept    = resetn && can_issue && any;
    assign req_ready = accept ? grant : '0;
    assign rsp_valid = (state == FULL) ? NREQ'(1) << own : '0;

    assign alu_a  = any ? req_a[int'(gidx)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign alu_b  = any ? req_b[int'(gidx)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign alu_op = any ? req_op[int'(gidx)*3 +: 3] : '0;

    always_comb state_next = accept ? FULL : rsp_fire ? EMPTY : state;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= EMPTY;
        else state <= state_next;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            own        <= '0;
            last       <= IW'(NREQ - 1);
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else if (accept) begin
            own        <= gidx;
            last       <= gidx;
            rsp_result <= alu_result;
            rsp_flags  <= pack_flags(alu_ovf, alu_cout, alu_zero);
        end

`ifdef ALU_SHARE_ARB_STATS_EN
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            stat_grants <= '0;
            stat_stalls <= '0;
        end else begin
            if (accept) stat_grants[int'(gidx)*16 +: 16] <= stat_grants[int'(gidx)*16 +: 16] + 16'd1;
            if (any && !accept) stat_stalls <= stat_stalls + 16'd1;
        end
`endif
endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Shares one combinational ALU between NREQ requesters (e.g. issue-side integer op, branch compare, address calc) with a valid/ready handshake on both the request and response side. Arbitration is round-robin, and the winning operation is registered into a single response slot. Sits between the requesters and the external ALU: it drives the ALU operands and op, and captures Result/Overflow/CarryOut/Zero. Back-to-back throughput is 1 op/cycle, with 1-cycle latency.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width (must match ALU)
- NREQ, 2, number of requesters, legal 2..4

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request valid per requester
- req_ready  out  NREQ  request accepted this cycle (one-hot or zero)
- req_a  in  NREQ*DATA_WIDTH  operand A, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_b  in  NREQ*DATA_WIDTH  operand B, same packing
- req_op  in  NREQ*3  3-bit ALU op, same packing, ALU encoding
- rsp_valid  out  NREQ  response valid, at most one bit set
- rsp_ready  in  NREQ  response consumed by requester i
- rsp_result  out  DATA_WIDTH  registered Result
- rsp_flags  out  3  registered {Overflow, CarryOut, Zero}
- alu_a, alu_b  out  DATA_WIDTH  to ALU A/B
- alu_op  out  3  to ALU ALUop
- alu_result  in  DATA_WIDTH  from ALU Result
- alu_ovf, alu_cout, alu_zero  in  1  from ALU flags

## Operation
- Response slot state: EMPTY or FULL, with owner index `own` and the stored result/flags.
- `rsp_fire` = FULL & rsp_ready[own]. `can_issue` = EMPTY | rsp_fire.
- Grant: round-robin over req_valid. Search starts at `last`+1 mod NREQ.
  - `last` resets to NREQ-1, so requester 0 wins first.
  - `last` updates only on an accepted grant.
- req_ready[g] = can_issue & (g is the granted index). All other bits are 0.
- alu_a/alu_b/alu_op are muxed from the granted requester. They are 0 when nothing is granted.
- On accept (req_valid[g] & req_ready[g]):
  - slot <= {alu_result, flags}, own <= g, state FULL.
- On rsp_fire without accept: state EMPTY.
- Fire and accept in the same cycle: slot is overwritten with the new op, stays FULL, and owner changes as granted.
- rsp_valid[i] = FULL & (own == i).
- While FULL and not firing:
  - Slot contents are frozen.
  - All req_ready are 0.
- Requester rules:
  - Must hold valid and operands stable until ready.
  - Must not derive req_valid from req_ready.
- Arbiter rules:
  - req_ready depends combinationally on req_valid and rsp_ready.
  - The arbiter contains no internal comb loop.
- Width: the arbiter performs no arithmetic on operands. Pointer arithmetic is mod NREQ.

## Timing
- Reset values: rsp_valid=0, req_ready=0, rsp_result=0, rsp_flags=0, last=NREQ-1, state EMPTY. alu_* outputs are 0 when no request is present.
- Reset is asynchronous. Asserting it mid-operation drops rsp_valid immediately, and the pending response is lost.
- Latency: accept at edge N gives rsp_valid high after edge N, visible in cycle N+1.
- With rsp_ready held high, one op completes per cycle. Grants rotate among all valid requesters, so no requester starves beyond NREQ-1 grants.
- A single valid requester is granted every cycle regardless of `last`.

## Configuration
- ALU_SHARE_ARB_STATS_EN defined adds the following ports:
  - `stat_grants` out NREQ*16: per-requester accept counters.
  - `stat_stalls` out 16: increments each cycle with any req_valid set and no accept.
  - All counters reset to 0 and wrap at 2^16.
- Undefined: those ports and counters do not exist. All other behaviour is identical.

## Structure
- The shared package holds:
  - ALU op encodings: AND 000, OR 001, ADD 010, SLTU 011, XOR 100, NOR 101, SUB 110, SLT 111.
  - The flag bit order {Overflow, CarryOut, Zero}.
  - Slot state constants EMPTY/FULL.
- One sub-module: `rr_pick`, a combinational round-robin picker.
  - Inputs: valid vector, `last`.
  - Outputs: one-hot grant, index, any.

## Test plan
- Reset: hold resetn=0 with all req_valid=1. Required: rsp_valid=0 and req_ready=0. After release, the first grant goes to requester 0.
- Single op: req0 ADD A=5 B=7, rsp_ready=1. Required: next cycle rsp_valid=01, rsp_result=12, flags=000.
- Fairness: NREQ=2, both valid every cycle, rsp_ready=11. Required: grants 0,1,0,1,0,1 with no idle cycles.
- Backpressure: req1 SUB A=3 B=3, rsp_ready[1]=0 for 3 cycles while req0 is valid.
  - Required: result 0 with Zero=1 held stable, and req_ready=00 for those cycles.
  - The cycle rsp_ready[1]=1 is also the cycle req0 is accepted.
- Flags: req0 SLTU A=1 B=2 gives result 1, CarryOut=1. req1 ADD A=0x7FFFFFFF B=1 gives result 0x80000000, Overflow=1.
- Async reset while FULL: rsp_valid falls before the next clk edge. With ALU_SHARE_ARB_STATS_EN defined, counters read 0 after reset.
